keypad_event_encoder: RTL
=========================

# keypad_event_encoder

Converts the debounced key-level vector from the input debouncer into a stream of press/release events for the CHIP-8 core and OSD logic. A round-robin scanner compares each key's current level with the last level it reported. On a mismatch it pushes one `{key, press}` event into a small FIFO, which the consumer drains through a valid/ready handshake. No edge is ever dropped under backpressure; the consumer always converges to the true key state.

## Interface
- `width`, 16: number of key lines. Must be ≥ 2.
- `depth_log2`, 2: FIFO depth is 2**`depth_log2` entries.
- `kw`, `$clog2(width)`: key-index width. Localparam, derived.

- `clk`  in  1: sole clock; everything is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in`  in  [width:1]: debounced key levels, 1 = pressed, synchronous to `clk`.
- `ev_valid`  out  1: FIFO head holds an event.
- `ev_ready`  in  1: consumer accepts head this cycle.
- `ev_key`  out  kw: key index of head; `in[n]` maps to `ev_key = n-1`.
- `ev_press`  out  1: 1 = press, 0 = release.
- `pending`  out  1: registered; some key's level differs from its reported level.

## Operation
- `level_r` is a register of `in`. `reported[width:1]` holds the last level pushed per key.
- `ptr` advances 0 → `width-1` → 0 every cycle, unconditionally, including non-power-of-2 wrap.
- Let `k` = key at `ptr`. A push occurs when `level_r[k] != reported[k]` and the FIFO can accept.
  - On push, the entry is `{ptr, level_r[k]}` and `reported[k] <= level_r[k]`.
- FIFO can accept when count < depth, or when a pop happens in the same cycle.
- If the FIFO is full without a pop, nothing is pushed and `reported` is unchanged. The key is retried on its next visit, so no event is lost.
- A press and release of the same key that both occur between scanner visits produce no event, because the net level is unchanged.
- Pop happens when `ev_valid && ev_ready`.
  - FIFO is show-ahead: `ev_key` and `ev_press` are valid whenever `ev_valid` is high.
  - Head data is stable while `ev_valid && !ev_ready`.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Events for a single key always alternate press/release, starting with press after reset.

## Timing
- Reset values: `ev_valid=0`, `pending=0`, `ev_key=0`, `ev_press=0`, `level_r=0`, `reported=0`, `ptr=0`, FIFO empty.
- Reset is asynchronous and may be asserted mid-operation. It discards queued events and clears `reported`.
  - Keys still held after reset release produce fresh press events.
- Latency, with FIFO not full:
  - `in` change sampled into `level_r` at edge t0.
  - Push at edge t0+1+d, where d ∈ [0, width-1] is the scanner distance to the key.
  - `ev_valid` is high after that edge.
- Best case is 2 edges from `in` change to `ev_valid`. Worst case is width+1 edges.
- `pending` is the OR-reduce of `level_r ^ reported`, registered, so it lags by 1 cycle.
- FIFO throughput: 1 push and 1 pop per cycle.

## Structure
- No shared package. `kw` is derived locally with `$clog2`.
- One sub-module, `event_fifo`:
  - Parameters: data width `kw+1` and `depth_log2`.
  - Ports: `clk`/`reset`, push/full, pop/empty, show-ahead data.
  - Count register is `depth_log2+1` bits wide.
- The top level holds `level_r`, `reported`, `ptr`, and the compare/push logic.

## Test plan
- Reset, then `in[3]=1`, with `ev_ready=1` throughout:
  - Exactly one event `{key=2, press=1}`, within 17 cycles.
  - `in[3]=0` then gives `{2,0}`.
- Assert `in[1]` and `in[16]` on the same edge with `ptr=0`:
  - Events in scan order: `{0,1}`, then `{15,1}`.
  - `pending` is 0 after both.
- Hold `ev_ready=0` and press 6 keys:
  - Exactly 4 events are queued, and `pending` stays 1.
  - Head data stays stable.
  - Raise `ev_ready`: all 6 press events arrive, each key exactly once, and `pending` falls to 0.
- Pulse `in[5]` high for 1 cycle while `ptr` is far from key 4:
  - No event is produced, and `pending` returns to 0.
- Press key 7 with `ev_ready=0`, then assert `reset` asynchronously mid-cycle while the key is still held:
  - Outputs go to reset values immediately.
  - After release of `reset`, a fresh `{6,1}` event appears.
- With the FIFO full and a pop coinciding with a scanner hit:
  - Push is accepted, count stays 4, and ordering is preserved.

Source files
------------

// File: rtl/event_fifo.sv
// Show-ahead FIFO for key events: the head is visible whenever not empty, one push and one pop per cycle.
// A push while full is taken only if a pop happens in the same cycle; the head is held while it is not popped.
module event_fifo #(
  parameter int dw         = 5,
  parameter int depth_log2 = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [dw-1:0] push_dat_i,
  output logic          full_o,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [dw-1:0] head_dat_o
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2-1:0] ptr_one  = depth_log2'(1);
  localparam logic [depth_log2:0]   cnt_one  = (depth_log2+1)'(1);
  localparam logic [depth_log2:0]   cnt_full = (depth_log2+1)'(depth);

  logic [dw-1:0]         mem_q [depth];
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == cnt_full);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_one;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_one;
    if (do_push && !do_pop)      count_d = count_q + cnt_one;
    else if (do_pop && !do_push) count_d = count_q - cnt_one;
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Round-robin scanner turning debounced key levels into {key, press} events; in-to-valid latency 2..width+1 edges.
// When the FIFO is full the key stays unreported and is retried on its next visit, so no edge is lost.
module keypad_event_encoder #(
  parameter  int width      = 16,
  parameter  int depth_log2 = 2,
  localparam int kw         = $clog2(width)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [width:1] in,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [kw-1:0]  ev_key,
  output logic           ev_press,
  output logic           pending
);

  localparam logic [kw-1:0] ptr_last = kw'(width - 1);
  localparam logic [kw-1:0] ptr_one  = kw'(1);

  // Bit n-1 of these vectors corresponds to in[n], so the scan pointer is the event key directly.
  logic [width-1:0] level_q;
  logic [width-1:0] reported_q, reported_d;
  logic [kw-1:0]    ptr_q, ptr_d;
  logic             pending_q, pending_d;

  logic             mismatch, push;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [kw:0]      head_dat;

  assign fifo_pop = ev_ready && !fifo_empty;
  assign mismatch = (level_q[ptr_q] != reported_q[ptr_q]);
  assign push     = mismatch && (!fifo_full || fifo_pop);

  always_comb begin
    ptr_d      = (ptr_q == ptr_last) ? '0 : ptr_q + ptr_one;
    reported_d = reported_q;
    if (push) reported_d[ptr_q] = level_q[ptr_q];
    pending_d  = |(level_q ^ reported_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      reported_q <= '0;
      ptr_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      level_q    <= in;
      reported_q <= reported_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
    end
  end

  event_fifo #(
    .dw         (kw + 1),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i ({ptr_q, level_q[ptr_q]}),
    .full_o     (fifo_full),
    .pop_i      (fifo_pop),
    .empty_o    (fifo_empty),
    .head_dat_o (head_dat)
  );

  assign ev_valid = !fifo_empty;
  assign ev_key   = head_dat[kw:1];
  assign ev_press = head_dat[0];
  assign pending  = pending_q;

endmodule
